// File: rtl/md5_ctrl_pkg.sv
// Shared register map, ID constant and bank helpers for the md5 multi-unit control block.
package md5_ctrl_pkg;

    localparam int MAX_UNITS = 128;

    localparam logic [2:0] REG_BANK   = 3'd0;
    localparam logic [2:0] REG_RESET  = 3'd1;
    localparam logic [2:0] REG_START  = 3'd2;
    localparam logic [2:0] REG_DONE   = 3'd3;
    localparam logic [2:0] REG_IRQ_EN = 3'd4;
    localparam logic [2:0] REG_BUSY   = 3'd5;
    localparam logic [2:0] REG_ID     = 3'd6;
    localparam logic [2:0] REG_CYCLES = 3'd7;

    localparam logic [15:0] ID_MAGIC = 16'h4D35;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Unit vectors are widened to MAX_UNITS so one helper serves every NUM_UNITS.
    function automatic logic [31:0] bank_slice(input logic [MAX_UNITS-1:0] v, input int unsigned b);
        return v[b*32 +: 32];
    endfunction

    function automatic logic [MAX_UNITS-1:0] bank_place(input logic [31:0] w, input int unsigned b);
        logic [MAX_UNITS-1:0] r;
        r = '0;
        r[b*32 +: 32] = w;
        return r;
    endfunction

endpackage

// File: rtl/md5_multi_control_unit_status.sv
// Per-unit done edge detect, sticky done bit and busy tracking.
module md5_unit_status (
    input  logic clk,
    input  logic reset_n,
    input  logic start_p,
    input  logic reset_p,
    input  logic w1c,
    input  logic done,
    output logic sticky,
    output logic busy
);

    logic done_q;
    logic done_rise;

    assign done_rise = done & ~done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
            sticky <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done_q <= done;
            // A completion always lands, even against a clear in the same cycle.
            if (done_rise)
                sticky <= 1'b1;
            else if (w1c || reset_p || start_p)
                sticky <= 1'b0;
            if (start_p)
                busy <= 1'b1;
            else if (done_rise || reset_p)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/md5_multi_control.sv
// Avalon-MM control/status for up to 128 md5 units: pulses, sticky done, busy, irq, cycle counter.
module md5_multi_control
    import md5_ctrl_pkg::*;
#(
    parameter int          NUM_UNITS = 32,
    parameter logic [7:0]  VERSION   = 8'h02
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic [NUM_UNITS-1:0] md5_reset,
    output logic [NUM_UNITS-1:0] md5_start,
    input  logic [NUM_UNITS-1:0] md5_done,
    output logic                 irq
);

    localparam int NUM_BANKS = (NUM_UNITS + 31) / 32;
    localparam int BANK_W    = (clog2(NUM_BANKS) < 1) ? 1 : clog2(NUM_BANKS);
    localparam logic [31:0] NU32 = NUM_UNITS;

    logic [BANK_W-1:0]    bank_sel;
    logic [NUM_UNITS-1:0] done_sticky, busy, irq_en;
    logic [31:0]          cycles;

    logic                 wr, rd;
    logic [MAX_UNITS-1:0] wr_wide, mask_wide, sticky_wide, busy_wide, irq_en_wide;
    logic [NUM_UNITS-1:0] wr_bits, bank_mask, start_nxt, reset_nxt, w1c;
    logic [31:0]          rd_val;
    logic                 unused;

    // A simultaneous read and write performs only the write.
    assign wr = avs_write;
    assign rd = avs_read & ~avs_write;

    always_comb begin
        wr_wide     = bank_place(avs_writedata, 32'(bank_sel));
        mask_wide   = bank_place(32'hFFFF_FFFF, 32'(bank_sel));
        sticky_wide = '0;
        busy_wide   = '0;
        irq_en_wide = '0;
        sticky_wide[NUM_UNITS-1:0] = done_sticky;
        busy_wide[NUM_UNITS-1:0]   = busy;
        irq_en_wide[NUM_UNITS-1:0] = irq_en;
    end

    assign wr_bits   = wr_wide[NUM_UNITS-1:0];
    assign bank_mask = mask_wide[NUM_UNITS-1:0];
    assign start_nxt = (wr && avs_address == REG_START) ? wr_bits : '0;
    assign reset_nxt = (wr && avs_address == REG_RESET) ? wr_bits : '0;
    assign w1c       = (wr && avs_address == REG_DONE)  ? wr_bits : '0;
    assign unused    = ^{wr_wide, mask_wide};

    always_comb begin
        rd_val = '0;
        case (avs_address)
            REG_BANK:   rd_val = 32'(bank_sel);
            REG_DONE:   rd_val = bank_slice(sticky_wide, 32'(bank_sel));
            REG_IRQ_EN: rd_val = bank_slice(irq_en_wide, 32'(bank_sel));
            REG_BUSY:   rd_val = bank_slice(busy_wide, 32'(bank_sel));
            REG_ID:     rd_val = {ID_MAGIC, VERSION, NU32[7:0]};
            REG_CYCLES: rd_val = cycles;
            default:    rd_val = '0;
        endcase
    end

    // Busy/sticky see the decoded write directly so they move on the same edge as the pulse.
    md5_unit_status u_unit [NUM_UNITS-1:0] (
        .clk     (clk),
        .reset_n (reset_n),
        .start_p (start_nxt),
        .reset_p (reset_nxt),
        .w1c     (w1c),
        .done    (md5_done),
        .sticky  (done_sticky),
        .busy    (busy)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_sel     <= '0;
            irq_en       <= '0;
            cycles       <= '0;
            md5_reset    <= '0;
            md5_start    <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            md5_reset <= reset_nxt;
            md5_start <= start_nxt;
            irq       <= |(done_sticky & irq_en);
            if (wr && avs_address == REG_CYCLES)
                cycles <= '0;
            else
                cycles <= cycles + 32'd1;
            if (wr && avs_address == REG_BANK && avs_writedata < 32'(NUM_BANKS))
                bank_sel <= avs_writedata[BANK_W-1:0];
            if (wr && avs_address == REG_IRQ_EN)
                irq_en <= (irq_en & ~bank_mask) | wr_bits;
            if (rd)
                avs_readdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_md5_multi_control.sv
// Directed bench: a 32-unit and a 40-unit instance share the Avalon bus.
module tb_md5_multi_control;
    import md5_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] rdata, rdata40;
    logic [31:0] md5_reset, md5_start, md5_done = '0;
    logic [39:0] md5_reset40, md5_start40, md5_done40 = '0;
    logic        irq, irq40;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    md5_multi_control #(.NUM_UNITS(32), .VERSION(8'h02)) dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rdata),
        .md5_reset(md5_reset), .md5_start(md5_start), .md5_done(md5_done), .irq(irq));

    md5_multi_control #(.NUM_UNITS(40), .VERSION(8'h02)) dut40 (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rdata40),
        .md5_reset(md5_reset40), .md5_start(md5_start40), .md5_done(md5_done40), .irq(irq40));

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] q, output logic [31:0] q40);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        q = rdata; q40 = rdata40;
    endtask

    task automatic test_reset;
        logic [31:0] q, q40;
        #1;
        tests++;
        if ({rdata, md5_reset, md5_start, irq} !== '0) begin
            fails++; $display("FAIL reset_outs32: got rd=%h rst=%h st=%h irq=%b want 0", rdata, md5_reset, md5_start, irq);
        end
        tests++;
        if ({rdata40, md5_reset40, md5_start40, irq40} !== '0) begin
            fails++; $display("FAIL reset_outs40: got rd=%h rst=%h st=%h irq=%b want 0", rdata40, md5_reset40, md5_start40, irq40);
        end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        rd_reg(REG_ID, q, q40);
        tests++;
        if (q !== 32'h4D35_0220) begin fails++; $display("FAIL id32: got %h want 4d350220", q); end
        tests++;
        if (q40 !== 32'h4D35_0228) begin fails++; $display("FAIL id40: got %h want 4d350228", q40); end
    endtask

    task automatic test_start;
        logic [31:0] q, q40;
        wr_reg(REG_START, 32'h5);
        tests++;
        if (md5_start !== 32'h5) begin fails++; $display("FAIL start_pulse: got %h want 5", md5_start); end
        @(negedge clk);
        tests++;
        if (md5_start !== 32'h0) begin fails++; $display("FAIL start_pulse_end: got %h want 0", md5_start); end
        rd_reg(REG_BUSY, q, q40);
        tests++;
        if (q !== 32'h5) begin fails++; $display("FAIL busy_after_start: got %h want 5", q); end
        // Done edge and DONE read in the same cycle: read sees the pre-edge value.
        md5_done[2] = 1'b1;
        avs_address = REG_DONE; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        tests++;
        if (rdata !== 32'h0) begin fails++; $display("FAIL done_race: got %h want 0", rdata); end
        rd_reg(REG_DONE, q, q40);
        tests++;
        if (q !== 32'h4) begin fails++; $display("FAIL done_sticky: got %h want 4", q); end
        rd_reg(REG_BUSY, q, q40);
        tests++;
        if (q !== 32'h1) begin fails++; $display("FAIL busy_after_done: got %h want 1", q); end
    endtask

    task automatic test_irq;
        logic [31:0] q, q40;
        md5_done = '0;
        wr_reg(REG_DONE, 32'hFFFF_FFFF);
        wr_reg(REG_IRQ_EN, 32'h4);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b want 0", irq); end
        md5_done[2] = 1'b1;
        @(negedge clk);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_early: got %b want 0", irq); end
        @(negedge clk);
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL irq_rise: got %b want 1", irq); end
        wr_reg(REG_DONE, 32'h4);
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL irq_hold: got %b want 1", irq); end
        @(negedge clk);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_fall: got %b want 0", irq); end
        md5_done[0] = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_masked: got %b want 0", irq); end
        rd_reg(REG_DONE, q, q40);
        tests++;
        if (q !== 32'h1) begin fails++; $display("FAIL done_unit0: got %h want 1", q); end
    endtask

    task automatic test_set_wins;
        logic [31:0] q, q40;
        md5_done = '0;
        wr_reg(REG_DONE, 32'hFFFF_FFFF);
        @(negedge clk);
        avs_address = REG_DONE; avs_writedata = 32'h1; avs_write = 1'b1;
        md5_done[0] = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        rd_reg(REG_DONE, q, q40);
        tests++;
        if (q !== 32'h1) begin fails++; $display("FAIL w1c_vs_set: got %h want 1", q); end
        @(negedge clk);
        avs_address = REG_START; avs_writedata = 32'h2; avs_write = 1'b1;
        md5_done[1] = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        rd_reg(REG_BUSY, q, q40);
        tests++;
        if (q !== 32'h2) begin fails++; $display("FAIL start_vs_done_busy: got %h want 2", q); end
        rd_reg(REG_DONE, q, q40);
        tests++;
        if (q !== 32'h3) begin fails++; $display("FAIL start_vs_done_sticky: got %h want 3", q); end
        wr_reg(REG_RESET, 32'h2);
        tests++;
        if (md5_reset !== 32'h2) begin fails++; $display("FAIL reset_pulse: got %h want 2", md5_reset); end
        @(negedge clk);
        tests++;
        if (md5_reset !== 32'h0) begin fails++; $display("FAIL reset_pulse_end: got %h want 0", md5_reset); end
        rd_reg(REG_BUSY, q, q40);
        tests++;
        if (q !== 32'h0) begin fails++; $display("FAIL busy_after_reset: got %h want 0", q); end
        rd_reg(REG_DONE, q, q40);
        tests++;
        if (q !== 32'h1) begin fails++; $display("FAIL done_after_reset: got %h want 1", q); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        avs_address = REG_START; avs_writedata = 32'h1; avs_write = 1'b1;
        @(negedge clk);
        tests++;
        if (md5_start !== 32'h1) begin fails++; $display("FAIL b2b_first: got %h want 1", md5_start); end
        avs_writedata = 32'h8;
        @(negedge clk);
        avs_write = 1'b0;
        tests++;
        if (md5_start !== 32'h8) begin fails++; $display("FAIL b2b_second: got %h want 8", md5_start); end
        @(negedge clk);
        tests++;
        if (md5_start !== 32'h0) begin fails++; $display("FAIL b2b_end: got %h want 0", md5_start); end
    endtask

    task automatic test_rw_same;
        logic [31:0] q, q40;
        wr_reg(REG_IRQ_EN, 32'hA5);
        rd_reg(REG_ID, q, q40);
        @(negedge clk);
        avs_address = REG_IRQ_EN; avs_writedata = 32'h0; avs_read = 1'b1; avs_write = 1'b1;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        tests++;
        if (rdata !== 32'h4D35_0220) begin fails++; $display("FAIL rw_hold: got %h want 4d350220", rdata); end
        rd_reg(REG_IRQ_EN, q, q40);
        tests++;
        if (q !== 32'h0) begin fails++; $display("FAIL rw_write_done: got %h want 0", q); end
    endtask

    task automatic test_bank40;
        logic [31:0] q, q40;
        wr_reg(REG_BANK, 32'h1);
        wr_reg(REG_START, 32'hFFFF_FFFF);
        tests++;
        if (md5_start40 !== 40'hFF_0000_0000) begin fails++; $display("FAIL bank1_start40: got %h want ff00000000", md5_start40); end
        tests++;
        if (md5_start !== 32'hFFFF_FFFF) begin fails++; $display("FAIL bank_ignored32: got %h want ffffffff", md5_start); end
        rd_reg(REG_BUSY, q, q40);
        tests++;
        if (q40 !== 32'h0000_00FF) begin fails++; $display("FAIL bank1_busy40: got %h want 000000ff", q40); end
        wr_reg(REG_BANK, 32'h2);
        rd_reg(REG_BANK, q, q40);
        tests++;
        if (q40 !== 32'h1) begin fails++; $display("FAIL bank_oob40: got %h want 1", q40); end
        tests++;
        if (q !== 32'h0) begin fails++; $display("FAIL bank_oob32: got %h want 0", q); end
    endtask

    task automatic test_cycles;
        logic [31:0] q, q40;
        wr_reg(REG_CYCLES, 32'h0);
        repeat (100) @(negedge clk);
        rd_reg(REG_CYCLES, q, q40);
        tests++;
        if (q < 32'd100 || q > 32'd102) begin fails++; $display("FAIL cycles_100: got %0d want 100..102", q); end
        @(negedge clk);
        force dut.cycles = 32'hFFFF_FFFF;
        #1 release dut.cycles;
        avs_address = REG_CYCLES; avs_read = 1'b1;
        @(negedge clk);
        tests++;
        if (rdata !== 32'hFFFF_FFFF) begin fails++; $display("FAIL cycles_max: got %h want ffffffff", rdata); end
        @(negedge clk);
        avs_read = 1'b0;
        tests++;
        if (rdata !== 32'h0) begin fails++; $display("FAIL cycles_wrap: got %h want 0", rdata); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] q, q40;
        md5_done = '0;
        wr_reg(REG_RESET, 32'hFFFF_FFFF);
        wr_reg(REG_DONE, 32'hFFFF_FFFF);
        wr_reg(REG_START, 32'hF);
        wr_reg(REG_IRQ_EN, 32'h10);
        md5_done[4] = 1'b1;
        rd_reg(REG_BUSY, q, q40);
        tests++;
        if (q !== 32'hF) begin fails++; $display("FAIL mid_busy: got %h want f", q); end
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL mid_irq: got %b want 1", irq); end
        @(negedge clk);
        avs_address = REG_START; avs_writedata = 32'hF; avs_write = 1'b1;
        @(posedge clk);
        #2 reset_n = 1'b0;
        avs_write = 1'b0;
        #1;
        tests++;
        if ({rdata, md5_reset, md5_start, irq} !== '0) begin
            fails++; $display("FAIL async_reset: got rd=%h rst=%h st=%h irq=%b want 0", rdata, md5_reset, md5_start, irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        rd_reg(REG_BUSY, q, q40);
        tests++;
        if (q !== 32'h0) begin fails++; $display("FAIL busy_post_reset: got %h want 0", q); end
        rd_reg(REG_BANK, q, q40);
        tests++;
        if (q40 !== 32'h0) begin fails++; $display("FAIL bank_post_reset: got %h want 0", q40); end
    endtask

    initial begin
        test_reset;
        test_start;
        test_irq;
        test_set_wins;
        test_back_to_back;
        test_rw_same;
        test_bank40;
        test_cycles;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
